// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO that feeds a UART transmitter one byte at a time. Writes are
//   queued in a circular buffer. A small launcher FSM pops the head byte and
//   strobes the transmitter. It then waits for the transmitter to go busy and
//   idle again, or gives up after four quiet cycles.
//
// Ports
//   i_Clock      sole clock, rising edge
//   i_Rst        synchronous active-high reset
//   i_Wr_DV      write strobe, one byte per cycle while high
//   i_Wr_Byte    write data
//   o_Full       registered, count == DEPTH
//   o_Empty      registered, count == 0
//   o_Count      registered byte count
//   o_Overflow   one-cycle pulse after a write was dropped because full
//   o_Tx_DV      one-cycle start strobe to the transmitter
//   o_Tx_Byte    byte for the transmitter, held until the next pop
//   i_Tx_Active  transmitter busy flag
//   o_Busy       launcher is in any state other than IDLE
module uart_tx_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst,
  input  logic                     i_Wr_DV,
  input  logic [7:0]               i_Wr_Byte,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Overflow,
  output logic                     o_Tx_DV,
  output logic [7:0]               o_Tx_Byte,
  input  logic                     i_Tx_Active,
  output logic                     o_Busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL      = CW'(DEPTH);
  localparam logic [1:0]    C_WAIT_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LAUNCH      = 2'd1,
    WAIT_ACTIVE = 2'd2,
    WAIT_DONE   = 2'd3
  } state_t;

  logic [7:0]    r_Mem [DEPTH];
  logic [AW-1:0] r_Wr_Ptr;
  logic [AW-1:0] r_Rd_Ptr;
  logic [CW-1:0] r_Count;
  logic          r_Full;
  logic          r_Empty;
  logic          r_Overflow;

  state_t        r_State;
  logic          r_Tx_DV;
  logic [7:0]    r_Tx_Byte;
  logic          r_Busy;
  logic [1:0]    r_Wait_Cnt;

  logic          w_Wr;
  logic          w_Pop;
  logic [CW-1:0] w_Count_Next;

  // Fullness is judged before this edge's pop, so a pop never makes room
  // for a write arriving in the same cycle.
  assign w_Wr  = i_Wr_DV && !r_Full;
  assign w_Pop = (r_State == IDLE) && !r_Empty && !i_Tx_Active;

  always_comb begin
    w_Count_Next = r_Count;
    if (w_Wr && !w_Pop)
      w_Count_Next = r_Count + 1'b1;
    else if (!w_Wr && w_Pop)
      w_Count_Next = r_Count - 1'b1;
  end

  // Storage array, no reset needed: contents are only read behind the count.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst && w_Wr)
      r_Mem[r_Wr_Ptr] <= i_Wr_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_Wr_Ptr   <= '0;
      r_Rd_Ptr   <= '0;
      r_Count    <= '0;
      r_Full     <= 1'b0;
      r_Empty    <= 1'b1;
      r_Overflow <= 1'b0;
    end else begin
      if (w_Wr)
        r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      if (w_Pop)
        r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      r_Count    <= w_Count_Next;
      r_Full     <= (w_Count_Next == C_FULL);
      r_Empty    <= (w_Count_Next == '0);
      r_Overflow <= i_Wr_DV && r_Full;
    end
  end

  // Launcher FSM. o_Tx_DV is raised on the pop edge, so it is high exactly
  // for the LAUNCH cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_State    <= IDLE;
      r_Tx_DV    <= 1'b0;
      r_Tx_Byte  <= '0;
      r_Busy     <= 1'b0;
      r_Wait_Cnt <= '0;
    end else begin
      case (r_State)
        IDLE: begin
          r_Tx_DV <= 1'b0;
          if (w_Pop) begin
            r_Tx_Byte <= r_Mem[r_Rd_Ptr];
            r_Tx_DV   <= 1'b1;
            r_Busy    <= 1'b1;
            r_State   <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_Tx_DV    <= 1'b0;
          r_Wait_Cnt <= '0;
          r_State    <= WAIT_ACTIVE;
        end
        WAIT_ACTIVE: begin
          r_Tx_DV <= 1'b0;
          if (i_Tx_Active) begin
            r_State <= WAIT_DONE;
          end else if (r_Wait_Cnt == C_WAIT_LAST) begin
            // Transmitter never answered; the popped byte is dropped.
            r_State <= IDLE;
            r_Busy  <= 1'b0;
          end else begin
            r_Wait_Cnt <= r_Wait_Cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          r_Tx_DV <= 1'b0;
          if (!i_Tx_Active) begin
            r_State <= IDLE;
            r_Busy  <= 1'b0;
          end
        end
        default: begin
          r_State <= IDLE;
          r_Tx_DV <= 1'b0;
          r_Busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Full     = r_Full;
  assign o_Empty    = r_Empty;
  assign o_Count    = r_Count;
  assign o_Overflow = r_Overflow;
  assign o_Tx_DV    = r_Tx_DV;
  assign o_Tx_Byte  = r_Tx_Byte;
  assign o_Busy     = r_Busy;

endmodule
